// File: rtl/cpu_wb_arbiter_if.sv
// Writeback-port bundle: ALU, LSU and MDU result channels plus the register-file write port.
interface cpu_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned IDXW = 5
);
    logic            alu_wen;
    logic [IDXW-1:0] alu_rd;
    logic [XLEN-1:0] alu_dat;
    logic            alu_stall;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [IDXW-1:0] lsu_rd;
    logic [31:0]     lsu_word;
    logic [2:0]      lsu_funct3;
    logic [1:0]      lsu_off;

    logic            mdu_valid;
    logic            mdu_ready;
    logic [IDXW-1:0] mdu_rd;
    logic [XLEN-1:0] mdu_dat;

    logic            rd_wen;
    logic [IDXW-1:0] rd_idx;
    logic [XLEN-1:0] rd_dat;

    modport slave (
        input  alu_wen, alu_rd, alu_dat,
        output alu_stall,
        input  lsu_valid, lsu_rd, lsu_word, lsu_funct3, lsu_off,
        output lsu_ready,
        input  mdu_valid, mdu_rd, mdu_dat,
        output mdu_ready,
        output rd_wen, rd_idx, rd_dat
    );

    modport master (
        output alu_wen, alu_rd, alu_dat,
        input  alu_stall,
        output lsu_valid, lsu_rd, lsu_word, lsu_funct3, lsu_off,
        input  lsu_ready,
        output mdu_valid, mdu_rd, mdu_dat,
        input  mdu_ready,
        input  rd_wen, rd_idx, rd_dat
    );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: ALU has fixed priority, LSU/MDU share leftover slots round-robin,
// and a starvation counter periodically stalls the ALU so pending loads/mul-div results drain.
module cpu_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned IDXW         = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic clk,
    input logic reset_n,
    cpu_wb_arbiter_if.slave bus
);
    localparam logic       GRANT_LSU = 1'b0;
    localparam logic       GRANT_MDU = 1'b1;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

    logic            last_grant;
    logic [3:0]      starve_cnt;
    logic [3:0]      starve_inc;
    logic            lsu_grant;
    logic            mdu_grant;
    logic            lsu_hs;
    logic            mdu_hs;
    logic            any_pending;

    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_dat;

    logic            wr_valid;
    logic [IDXW-1:0] wr_idx;
    logic [XLEN-1:0] wr_dat;

    // Ready is purely a function of valids, alu_wen, last_grant and reset.
    always_comb begin
        lsu_grant = 1'b0;
        mdu_grant = 1'b0;
        if (reset_n && !bus.alu_wen) begin
            if (bus.lsu_valid && bus.mdu_valid) begin
                lsu_grant = (last_grant == GRANT_MDU);
                mdu_grant = (last_grant == GRANT_LSU);
            end else begin
                lsu_grant = bus.lsu_valid;
                mdu_grant = bus.mdu_valid;
            end
        end
    end

    assign bus.lsu_ready = lsu_grant;
    assign bus.mdu_ready = mdu_grant;
    assign lsu_hs        = bus.lsu_valid & lsu_grant;
    assign mdu_hs        = bus.mdu_valid & mdu_grant;
    assign any_pending   = bus.lsu_valid | bus.mdu_valid;
    assign starve_inc    = starve_cnt + 4'd1;

    always_comb begin
        case (bus.lsu_off)
            2'd0:    load_byte = bus.lsu_word[7:0];
            2'd1:    load_byte = bus.lsu_word[15:8];
            2'd2:    load_byte = bus.lsu_word[23:16];
            default: load_byte = bus.lsu_word[31:24];
        endcase
        load_half = bus.lsu_off[1] ? bus.lsu_word[31:16] : bus.lsu_word[15:0];
        case (bus.lsu_funct3)
            3'b000:  load_dat = XLEN'($signed(load_byte));
            3'b100:  load_dat = XLEN'(load_byte);
            3'b001:  load_dat = XLEN'($signed(load_half));
            3'b101:  load_dat = XLEN'(load_half);
            default: load_dat = XLEN'($signed(bus.lsu_word));
        endcase
    end

    always_comb begin
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_dat   = '0;
        if (reset_n && bus.alu_wen) begin
            wr_valid = 1'b1;
            wr_idx   = bus.alu_rd;
            wr_dat   = bus.alu_dat;
        end else if (lsu_hs) begin
            wr_valid = 1'b1;
            wr_idx   = bus.lsu_rd;
            wr_dat   = load_dat;
        end else if (mdu_hs) begin
            wr_valid = 1'b1;
            wr_idx   = bus.mdu_rd;
            wr_dat   = bus.mdu_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.rd_wen    <= 1'b0;
            bus.rd_idx    <= '0;
            bus.rd_dat    <= '0;
            bus.alu_stall <= 1'b0;
            starve_cnt    <= '0;
            last_grant    <= GRANT_MDU;
        end else begin
            // x0 results are consumed but never written, and leave rd_idx/rd_dat untouched.
            bus.rd_wen <= wr_valid && (wr_idx != '0);
            if (wr_valid && (wr_idx != '0)) begin
                bus.rd_idx <= wr_idx;
                bus.rd_dat <= wr_dat;
            end

            if (lsu_hs) begin
                last_grant <= GRANT_LSU;
            end else if (mdu_hs) begin
                last_grant <= GRANT_MDU;
            end

            bus.alu_stall <= 1'b0;
            if (bus.alu_wen && any_pending) begin
                if (starve_inc == LIMIT) begin
                    starve_cnt    <= '0;
                    bus.alu_stall <= 1'b1;
                end else begin
                    starve_cnt <= starve_inc;
                end
            end else if (lsu_hs || mdu_hs || !any_pending) begin
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter: the driver queues expected register-file writes,
// a negedge monitor pops and compares every rd_wen pulse.
module tb_cpu_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cpu_wb_arbiter_if #(.XLEN(32), .IDXW(5)) bus();

    cpu_wb_arbiter #(.XLEN(32), .IDXW(5), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] idx, input logic [31:0] dat);
        exp_t e;
        e.idx = idx;
        e.dat = dat;
        if (idx != 5'd0) sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.alu_wen    = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_dat    = '0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_rd     = '0;
        bus.lsu_word   = '0;
        bus.lsu_funct3 = '0;
        bus.lsu_off    = '0;
        bus.mdu_valid  = 1'b0;
        bus.mdu_rd     = '0;
        bus.mdu_dat    = '0;
    endtask

    task automatic lsu_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] word, input logic [31:0] exp);
        int n;
        bus.lsu_valid  = 1'b1;
        bus.lsu_rd     = rd;
        bus.lsu_funct3 = f3;
        bus.lsu_off    = off;
        bus.lsu_word   = word;
        push(rd, exp);
        settle();
        n = 0;
        while (!bus.lsu_ready && n < 20) begin
            tick();
            n++;
        end
        chk("lsu_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        tick();
        bus.lsu_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.rd_wen === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got idx=%0d dat=0x%0h expected no write", bus.rd_idx, bus.rd_dat);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_idx", 32'(bus.rd_idx), 32'(e.idx));
                chk("rd_dat", bus.rd_dat, e.dat);
            end
        end
    end

    initial begin
        idle();
        reset_n = 1'b0;
        bus.lsu_valid = 1'b1;
        bus.mdu_valid = 1'b1;
        repeat (2) tick();
        chk("rst_rd_wen", 32'(bus.rd_wen), 32'd0);
        chk("rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        chk("rst_rd_dat", bus.rd_dat, 32'd0);
        chk("rst_stall", 32'(bus.alu_stall), 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        chk("rst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
        idle();
        reset_n = 1'b1;
        tick();

        // ALU only
        bus.alu_wen = 1'b1;
        bus.alu_rd  = 5'd5;
        bus.alu_dat = 32'h1234;
        push(5'd5, 32'h1234);
        tick();
        bus.alu_wen = 1'b0;
        tick();
        tick();
        chk("alu_after_wen", 32'(bus.rd_wen), 32'd0);
        chk("alu_hold_idx", 32'(bus.rd_idx), 32'd5);
        chk("alu_hold_dat", bus.rd_dat, 32'h1234);

        // Load extension
        lsu_load(5'd3, 3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF);
        lsu_load(5'd3, 3'b100, 2'd3, 32'h80FF7F01, 32'h00000080);
        lsu_load(5'd3, 3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF);
        lsu_load(5'd3, 3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01);
        lsu_load(5'd3, 3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01);
        tick();

        // Round-robin from reset: LSU wins first tie
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.lsu_valid  = 1'b1;
        bus.lsu_rd     = 5'd7;
        bus.lsu_funct3 = 3'b010;
        bus.lsu_word   = 32'h100;
        bus.mdu_valid  = 1'b1;
        bus.mdu_rd     = 5'd9;
        bus.mdu_dat    = 32'h200;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_lsu_ready", 32'(bus.lsu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_mdu_ready", 32'(bus.mdu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) push(5'd7, bus.lsu_word);
            else            push(5'd9, bus.mdu_dat);
            tick();
            if (i % 2 == 0) bus.lsu_word = bus.lsu_word + 32'd1;
            else            bus.mdu_dat  = bus.mdu_dat + 32'd1;
        end
        idle();
        tick();

        // Starvation with limit 4
        bus.alu_wen    = 1'b1;
        bus.alu_rd     = 5'd1;
        bus.lsu_valid  = 1'b1;
        bus.lsu_rd     = 5'd4;
        bus.lsu_funct3 = 3'b010;
        bus.lsu_word   = 32'hAAAA0000;
        for (int i = 0; i < 4; i++) begin
            bus.alu_dat = 32'h10 + 32'(i);
            push(5'd1, 32'h10 + 32'(i));
            settle();
            chk("starve_lsu_blocked", 32'(bus.lsu_ready), 32'd0);
            chk("starve_no_stall", 32'(bus.alu_stall), 32'd0);
            tick();
        end
        chk("starve_stall", 32'(bus.alu_stall), 32'd1);
        bus.alu_wen = 1'b0;
        settle();
        chk("starve_lsu_granted", 32'(bus.lsu_ready), 32'd1);
        push(5'd4, 32'hAAAA0000);
        tick();
        bus.lsu_valid = 1'b0;
        settle();
        chk("starve_stall_drop", 32'(bus.alu_stall), 32'd0);
        chk("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
        tick();

        // x0 destinations
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd0;
        bus.mdu_dat   = 32'hDEAD;
        settle();
        chk("x0_mdu_ready", 32'(bus.mdu_ready), 32'd1);
        tick();
        bus.mdu_valid = 1'b0;
        bus.alu_wen   = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_dat   = 32'hBEEF;
        settle();
        chk("x0_mdu_no_wen", 32'(bus.rd_wen), 32'd0);
        tick();
        bus.alu_wen = 1'b0;
        settle();
        chk("x0_alu_no_wen", 32'(bus.rd_wen), 32'd0);
        chk("x0_hold_idx", 32'(bus.rd_idx), 32'd4);
        chk("x0_hold_dat", bus.rd_dat, 32'hAAAA0000);
        tick();

        // Reset mid-stream
        bus.alu_wen = 1'b1;
        bus.alu_rd  = 5'd6;
        bus.alu_dat = 32'h55;
        push(5'd6, 32'h55);
        tick();
        bus.alu_wen   = 1'b0;
        reset_n       = 1'b0;
        bus.lsu_valid = 1'b1;
        bus.mdu_valid = 1'b1;
        settle();
        chk("mid_rst_write_seen", 32'(bus.rd_wen), 32'd1);
        chk("mid_rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        chk("mid_rst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
        tick();
        chk("mid_rst_rd_wen", 32'(bus.rd_wen), 32'd0);
        chk("mid_rst_rd_dat", bus.rd_dat, 32'd0);
        chk("mid_rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        chk("mid_rst_ready_held", 32'(bus.lsu_ready | bus.mdu_ready), 32'd0);
        // ALU result offered while reset is held must be discarded
        bus.alu_wen = 1'b1;
        bus.alu_rd  = 5'd8;
        bus.alu_dat = 32'h77;
        tick();
        idle();
        settle();
        chk("rst_alu_dropped", 32'(bus.rd_wen), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
